// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one repeated-subtraction divider among N_REQ requesters
module div_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] dividend,
    input  logic [N_REQ*W-1:0] divisor,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               done,
    output logic [IDW-1:0]     done_id,
    output logic [W-1:0]       quotient,
    output logic [W-1:0]       remainder,
    output logic               div_zero
);
    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d, id_q, id_d, did_q, did_d, win_id;
    logic [W-1:0]   n_q, n_d, p_q, p_d, q_q, q_d, quot_q, quot_d, rem_q, rem_d;
    logic           dz_q, dz_d, win_ok;
    int             idx;
    // round-robin arbiter: first requesting index at or after rr_q, wrapping
    always_comb begin
        win_ok = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_ok && req[IDW'(idx)]) begin
                win_ok = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end
    // next-state, datapath and result capture; results are registered on entry to DONE
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        n_d     = n_q;
        p_d     = p_q;
        q_d     = q_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        did_d   = did_q;
        case (state_q)
            IDLE: if (win_ok) begin
                id_d    = win_id;
                n_d     = dividend[int'(win_id)*W +: W];
                p_d     = divisor[int'(win_id)*W +: W];
                q_d     = '0;
                state_d = CHECK;
            end
            CHECK: if (p_q == '0) begin
                quot_d  = '1;
                rem_d   = n_q;
                dz_d    = 1'b1;
                did_d   = id_q;
                state_d = DONE;
            end else begin
                state_d = ITER;
            end
            ITER: if (n_q >= p_q) begin
                n_d = n_q - p_q;
                q_d = q_q + W'(1);
            end else begin
                quot_d  = q_q;
                rem_d   = n_q;
                dz_d    = 1'b0;
                did_d   = id_q;
                state_d = DONE;
            end
            DONE: begin
                rr_d    = (id_q == IDW'(N_REQ-1)) ? '0 : id_q + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            n_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            did_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            p_q     <= p_d;
            q_q     <= q_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            did_q   <= did_d;
        end
    end
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign grant     = busy ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign done_id   = did_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: table vectors, corner sequences and randomized round-robin jobs against a reference model
module tb_div_sched;
    localparam int N = 4, W = 16, IDW = 2;
    logic           clk = 1'b0, clear_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] dividend = '0, divisor = '0;
    logic [N-1:0]   grant;
    logic           busy, done, div_zero;
    logic [IDW-1:0] done_id;
    logic [W-1:0]   quotient, remainder;
    int errors = 0, checks = 0;

    div_sched #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk(clk), .clear_n(clear_n), .req(req), .dividend(dividend), .divisor(divisor),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a, b, q, r;
        logic        z;
        int          lat;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " grant"}, 32'(grant), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " done_id"}, 32'(done_id), 0);
        chk({tag, " quotient"}, 32'(quotient), 0);
        chk({tag, " remainder"}, 32'(remainder), 0);
        chk({tag, " div_zero"}, 32'(div_zero), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle timeout", 32'(busy), 0);
    endtask

    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 0;
        while (!ok && lat < 70000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) chk("done timeout", 32'(ok), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req     = '0;
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic run_job(input vec_t v);
        int lat = 0;
        bit found = 0, gbad = 0;
        wait_idle();
        dividend[v.id*W +: W] = v.a;
        divisor[v.id*W +: W]  = v.b;
        req = '0;
        req[v.id] = 1'b1;
        while (!found && lat < 70000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy && grant !== (N'(1) << v.id)) gbad = 1;
            if (!busy && grant !== '0) gbad = 1;
            if (done) found = 1;
        end
        req = '0;
        chk($sformatf("job%0d latency", v.id), 32'(lat), 32'(v.lat));
        chk($sformatf("job%0d done_id", v.id), 32'(done_id), 32'(v.id));
        chk($sformatf("job%0d quotient", v.id), 32'(quotient), 32'(v.q));
        chk($sformatf("job%0d remainder", v.id), 32'(remainder), 32'(v.r));
        chk($sformatf("job%0d div_zero", v.id), 32'(div_zero), 32'(v.z));
        chk($sformatf("job%0d grant bad", v.id), 32'(gbad), 0);
        @(negedge clk);
        chk($sformatf("job%0d done width", v.id), 32'(done), 0);
    endtask

    initial begin
        int lat, dn;
        bit ok;
        logic [N-1:0] pend;
        logic [15:0] ra[N], rb[N];
        int mptr, e;
        tbl[0] = '{0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17};
        tbl[1] = '{2, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 3};
        tbl[2] = '{1, 16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 2};
        tbl[3] = '{3, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 5};
        tbl[4] = '{1, 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 3};
        tbl[5] = '{2, 16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 4};
        tbl[6] = '{2, 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 65538};

        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        clear_n = 1'b1;

        for (int i = 0; i < 7; i++) run_job(tbl[i]);

        // reset in the middle of a long job
        wait_idle();
        dividend[0 +: W] = 16'd1000;
        divisor[0 +: W]  = 16'd1;
        req = 4'b0001;
        repeat (20) @(negedge clk);
        chk("midjob busy", 32'(busy), 1);
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1 chk_outputs_zero("async reset");
        req = '0;
        @(negedge clk);
        clear_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no done after abort", 32'(dn), 0);
        run_job('{3, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 5});

        // operands changed after grant are ignored
        wait_idle();
        dividend[0 +: W] = 16'd50;
        divisor[0 +: W]  = 16'd5;
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        dividend[0 +: W] = 16'd1234;
        divisor[0 +: W]  = 16'd3;
        wait_done(lat, ok);
        req = '0;
        chk("stable quotient", 32'(quotient), 10);
        chk("stable remainder", 32'(remainder), 0);

        // round robin with all requesters held
        do_reset();
        for (int i = 0; i < N; i++) begin
            dividend[i*W +: W] = 16'd10;
            divisor[i*W +: W]  = 16'd3;
        end
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done(lat, ok);
            if (j == 4) req = 4'b1001;
            chk($sformatf("rr%0d id", j), 32'(done_id), 32'(j % N));
            chk($sformatf("rr%0d q", j), 32'(quotient), 3);
            chk($sformatf("rr%0d r", j), 32'(remainder), 1);
            if (j > 0) chk($sformatf("rr%0d gap", j), 32'(lat), 7);
        end
        wait_done(lat, ok);
        chk("rr1001 first", 32'(done_id), 3);
        wait_done(lat, ok);
        req = '0;
        chk("rr1001 second", 32'(done_id), 0);

        // randomized batches against a round-robin reference model
        do_reset();
        mptr = 0;
        for (int b = 0; b < 12; b++) begin
            wait_idle();
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                ra[i] = 16'($urandom_range(0, 255));
                rb[i] = 16'($urandom_range(0, 31));
                dividend[i*W +: W] = ra[i];
                divisor[i*W +: W]  = rb[i];
            end
            req = pend;
            while (pend != '0) begin
                e = -1;
                for (int k = 0; k < N; k++)
                    if (e < 0 && pend[(mptr + k) % N]) e = (mptr + k) % N;
                wait_done(lat, ok);
                if (!ok) break;
                chk($sformatf("rand%0d id", b), 32'(done_id), 32'(e));
                chk($sformatf("rand%0d z", b), 32'(div_zero), 32'(rb[e] == 0));
                chk($sformatf("rand%0d q", b), 32'(quotient), rb[e] == 0 ? 32'hFFFF : 32'(ra[e] / rb[e]));
                chk($sformatf("rand%0d r", b), 32'(remainder), rb[e] == 0 ? 32'(ra[e]) : 32'(ra[e] % rb[e]));
                pend[e] = 1'b0;
                req[e]  = 1'b0;
                mptr    = (e + 1) % N;
            end
            req = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one repeated-subtraction divider engine among N_REQ requesters.
- Arbitrates requests and captures the winner's operands into the dividend (N) and divisor (P) registers.
- Sequences compare/subtract/increment-quotient until N < P, then returns quotient, remainder and a divide-by-zero flag tagged with the requester id.
- Sits between client blocks and the divider datapath; it replaces the single-user start/stop control flow.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 16, operand, quotient and remainder width in bits.
- IDW, 2, requester id width; must equal ceil(log2(N_REQ)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester job request, level.
- dividend  in  N_REQ*W  packed dividends; slice i is [i*W +: W].
- divisor  in  N_REQ*W  packed divisors; slice i is [i*W +: W].
- grant  out  N_REQ  one-hot owner of the engine.
- busy  out  1  engine not idle.
- done  out  1  one-cycle completion pulse.
- done_id  out  IDW  requester index of the completed job.
- quotient  out  W  result quotient.
- remainder  out  W  result remainder.
- div_zero  out  1  completed job had divisor 0.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE, rr_ptr=0, internal N/P/Q=0.
  - All outputs 0: grant, busy, done, done_id, quotient, remainder, div_zero.
  - A reset in the middle of a job aborts it with no done pulse. After release, arbitration restarts from index 0.
- States: IDLE, CHECK, ITER, DONE.
- IDLE:
  - If any req bit is set, pick the winner by scanning rr_ptr, rr_ptr+1, ... modulo N_REQ; the first set bit wins.
  - Latch id, N<=dividend[id], P<=divisor[id], Q<=0, then go to CHECK.
  - With no requests, stay in IDLE.
- CHECK:
  - If P==0, go to DONE with the zero flag set.
  - Otherwise go to ITER.
- ITER:
  - Each cycle with N>=P (unsigned): N<=N-P, Q<=Q+1, stay in ITER.
  - When N<P, go to DONE. No change to N or Q on that cycle.
- DONE:
  - On entry, register the results: quotient=Q, remainder=N, div_zero=0, done_id=id.
  - For the zero-divisor case: quotient={W{1'b1}}, remainder=dividend, div_zero=1.
  - done=1 for exactly this one cycle.
  - rr_ptr<=(id+1) mod N_REQ, then go to IDLE.
- Outputs:
  - quotient, remainder, div_zero and done_id hold their values until the next DONE.
  - grant[id]=1 from CHECK through DONE inclusive; grant is 0 in IDLE.
  - busy=1 in any state other than IDLE.
- Latency: req sampled in IDLE at edge k.
  - Normal job: done is high in cycle k+3+q, where q is the quotient.
  - Divide-by-zero: done is high in cycle k+2.
- Handshake:
  - The requester holds req, dividend and divisor stable until it sees done with done_id equal to its own index.
  - It deasserts req in the cycle after done.
  - If req is still held, rr_ptr has already moved past it, so it has lowest priority on the next arbitration.
- Operand capture: operands are sampled only in IDLE. Changes after grant are ignored.
- req dropped mid-job: the job still completes and done still pulses. No cancel path.
- Simultaneous requests: exactly one grant per job; the others wait in order. No requester starves; the worst-case wait is N_REQ-1 jobs.
- Arithmetic:
  - All operations are unsigned, W bits.
  - Q cannot overflow, because the quotient is at most the dividend.
  - The subtract happens only when N>=P, so there is no underflow.
- Back-to-back jobs: after DONE the engine spends one IDLE cycle, so the next job's CHECK occurs two cycles after DONE.

Test Plan:
- Single job: req[0]=1, 100/7, sampled at edge k → quotient=14, remainder=2, done_id=0, done high in cycle k+17 only; grant=4'b0001 during CHECK..DONE.
- Edge operands:
  - req[2]: 5/9 → q=0, r=5, done in cycle k+3.
  - Then 65535/1 → q=65535, r=0, done in cycle k+65538.
- Divide by zero: req[1]: 42/0 → div_zero=1, quotient=16'hFFFF, remainder=42, done in cycle k+2, done_id=1.
- Round robin:
  - req=4'b1111 held continuously, each job 10/3 → done_id sequence 0,1,2,3,0; every result q=3, r=1.
  - Then req=4'b1001 with rr_ptr=1 → serviced in order 3, then 0.
- Reset mid-ITER: 1000/1 running; pulse clear_n low asynchronously (mid-cycle) → all outputs 0 immediately and no done pulse.
  - After release, req[3]: 9/4 → q=2, r=1, done_id=3.
- Operand stability: change dividend[0] one cycle after grant during a 50/5 job → result is still q=10, r=0.
